// File: rtl/exu_csr_pkg.sv
// Shared types for the CSR execution pipe: op encoding, queue entry payload and the CSR ALU.
package exu_csr_pkg;

    localparam int unsigned CSR_DW     = 32;
    localparam int unsigned CSR_AW_W   = 12;
    localparam int unsigned CSR_RAW_W  = 5;
    localparam int unsigned CSR_ZIMM_W = 5;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic                  csr_we;
        logic [CSR_AW_W-1:0]   csr_waddr;
        logic [CSR_DW-1:0]     csr_wdata;
        logic                  reg_we;
        logic [CSR_RAW_W-1:0]  reg_waddr;
        logic [CSR_DW-1:0]     reg_wdata;
    } csr_entry_t;

    // New CSR value for a read-modify-write op.
    function automatic logic [CSR_DW-1:0] csr_alu(input csr_op_e op,
                                                  input logic [CSR_DW-1:0] rdata,
                                                  input logic [CSR_DW-1:0] src);
        logic [CSR_DW-1:0] res;
        res = rdata;
        case (op)
            CSR_RW:  res = src;
            CSR_RS:  res = rdata | src;
            CSR_RC:  res = rdata & ~src;
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_out_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; exposes storage and per-slot valid bits
// so the parent can search queued entries.
module csr_out_fifo
    import exu_csr_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = csr_entry_t,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  T                 data_i,
    output T                 head_o,
    output logic [CW-1:0]    count_o,
    output logic [PW-1:0]    rd_ptr_o,
    output T                 entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    T                 mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset: slots are only observed while their valid bit is set.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Flush overrides any same-cycle push/pop for the queue state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            vld_d    = '0;
        end else begin
            if (pop_i) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ptr_inc(rd_ptr_q);
            end
            if (push_i) begin
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = mem_q;
    assign valid_o   = vld_q;

endmodule

// File: rtl/exu_csr_pipe.sv
// CSR execution unit (CSRRW/RS/RC, reg and imm forms) feeding a DEPTH-entry result queue.
// Build option CSR_BYPASS_EN: forward queued CSR writes instead of stalling on a RAW hazard.
module exu_csr_pipe
    import exu_csr_pkg::*;
#(
    parameter int unsigned DW     = CSR_DW,
    parameter int unsigned CSR_AW = CSR_AW_W,
    parameter int unsigned RAW    = CSR_RAW_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            op_i,
    input  logic                  imm_sel_i,
    input  logic [DW-1:0]         op1_i,
    input  logic [CSR_ZIMM_W-1:0] zimm_i,
    input  logic [CSR_AW-1:0]     csr_addr_i,
    input  logic [DW-1:0]         csr_rdata_i,
    input  logic [RAW-1:0]        reg_waddr_i,
    input  logic                  int_assert_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  csr_we_o,
    output logic [CSR_AW-1:0]     csr_waddr_o,
    output logic [DW-1:0]         csr_wdata_o,
    output logic                  reg_we_o,
    output logic [RAW-1:0]        reg_waddr_o,
    output logic [DW-1:0]         reg_wdata_o,
    output logic                  hold_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    csr_op_e          op;
    logic [DW-1:0]    src;
    logic [DW-1:0]    rdata_eff;
    logic             hazard;
    logic             push;
    logic             pop;
    logic             match_hit;
    csr_entry_t       entry;
    csr_entry_t       head;
    csr_entry_t       entries [DEPTH];
    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] slot_vld;
`ifdef CSR_BYPASS_EN
    logic [DW-1:0]    match_data;
`endif

    // Scan oldest to youngest so the last hit is the youngest matching CSR write.
    always_comb begin : match_scan
        int unsigned slot;
        slot      = 0;
        match_hit = 1'b0;
`ifdef CSR_BYPASS_EN
        match_data = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = (32'(rd_ptr) + k) % DEPTH;
            if (slot_vld[PW'(slot)] && entries[PW'(slot)].csr_we &&
                (entries[PW'(slot)].csr_waddr == CSR_AW_W'(csr_addr_i))) begin
                match_hit = 1'b1;
`ifdef CSR_BYPASS_EN
                match_data = DW'(entries[PW'(slot)].csr_wdata);
`endif
            end
        end
    end

`ifdef CSR_BYPASS_EN
    assign hazard    = 1'b0;
    assign rdata_eff = match_hit ? match_data : csr_rdata_i;
`else
    assign hazard    = match_hit;
    assign rdata_eff = csr_rdata_i;
`endif

    assign op          = csr_op_e'(op_i);
    assign src         = imm_sel_i ? DW'(zimm_i) : op1_i;
    assign req_ready_o = ((count < CW'(DEPTH)) || out_ready_i) && !hazard;
    assign hold_o      = req_valid_i && !req_ready_o;
    assign out_valid_o = (count != '0);
    assign push        = req_valid_i && req_ready_o && !int_assert_i && !flush_i && (op != CSR_NOP);
    assign pop         = out_valid_o && out_ready_i;

    // zimm_i doubles as rs1 index, so a zero field suppresses RS/RC writes in both forms.
    always_comb begin
        entry           = '0;
        entry.csr_we    = (op == CSR_RW) || (zimm_i != '0);
        entry.csr_waddr = CSR_AW_W'(csr_addr_i);
        entry.csr_wdata = csr_alu(op, CSR_DW'(rdata_eff), CSR_DW'(src));
        entry.reg_we    = (reg_waddr_i != '0);
        entry.reg_waddr = CSR_RAW_W'(reg_waddr_i);
        entry.reg_wdata = CSR_DW'(rdata_eff);
    end

    csr_out_fifo #(
        .DEPTH (DEPTH),
        .T     (csr_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (flush_i),
        .data_i    (entry),
        .head_o    (head),
        .count_o   (count),
        .rd_ptr_o  (rd_ptr),
        .entries_o (entries),
        .valid_o   (slot_vld)
    );

    // Head is masked so an empty queue never shows stale payload.
    assign csr_we_o    = out_valid_o && head.csr_we;
    assign csr_waddr_o = out_valid_o ? CSR_AW'(head.csr_waddr) : '0;
    assign csr_wdata_o = out_valid_o ? DW'(head.csr_wdata)     : '0;
    assign reg_we_o    = out_valid_o && head.reg_we;
    assign reg_waddr_o = out_valid_o ? RAW'(head.reg_waddr)    : '0;
    assign reg_wdata_o = out_valid_o ? DW'(head.reg_wdata)     : '0;

endmodule

// File: doc/exu_csr_pipe.md
Name: exu_csr_pipe

Overview:
- Parametrised successor CSR execution unit. Computes CSRRW/CSRRS/CSRRC in both register and immediate forms, including the x0/zimm=0 write-suppression rules.
- Results go into a DEPTH-entry output queue with valid/ready handshakes on both sides, replacing the single-register hold scheme.
- Sits in EXU between the ID/EX register and the write-back arbiter. Drives both the CSR file write port and the GPR write-back.

Parameters:
- DW, 32: data width of CSR/GPR values.
- CSR_AW, 12: CSR address width.
- RAW, 5: GPR address width.
- DEPTH, 2: output queue entries (>=1). Count width is $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- op_i  in  2  operation: 01=RW, 10=RS, 11=RC; 00 is illegal and treated as no-op.
- imm_sel_i  in  1  use zero-extended zimm_i instead of op1_i.
- op1_i  in  DW  rs1 value.
- zimm_i  in  5  immediate field; also the rs1 index for the x0 check.
- csr_addr_i  in  CSR_AW  target CSR address.
- csr_rdata_i  in  DW  current CSR value from the CSR file.
- reg_waddr_i  in  RAW  destination rd.
- int_assert_i  in  1  interrupt taken; the request is squashed.
- flush_i  in  1  pipeline flush.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  write-back accepts the head.
- csr_we_o  out  1  head CSR write enable.
- csr_waddr_o  out  CSR_AW  head CSR write address.
- csr_wdata_o  out  DW  head CSR write data.
- reg_we_o  out  1  head GPR write enable.
- reg_waddr_o  out  RAW  head GPR write address.
- reg_wdata_o  out  DW  head GPR write data.
- hold_o  out  1  equals req_valid_i & ~req_ready_o.

Behaviour:
- Source operand: src = imm_sel_i ? {DW-5 zeros, zimm_i} : op1_i.
- CSR write data:
  - RW: src.
  - RS: rdata | src.
  - RC: rdata & ~src.
- CSR write enable: RW always writes. RS/RC write only if zimm_i != 0 (same field serves as rs1 index or immediate).
- GPR write: reg_we = (reg_waddr_i != 0). reg_wdata = rdata, where rdata is csr_rdata_i, or the forwarded value when the optional feature is enabled.
- Enqueue condition: req_valid_i & req_ready_o & ~int_assert_i & ~flush_i & (op_i != 00).
  - Requests arriving with int_assert_i or flush_i are consumed (ready honoured) but produce no entry.
  - An op_i=00 request is consumed and produces no entry.
- Dequeue condition: out_valid_o & out_ready_i.
- req_ready_o = (count < DEPTH) | out_ready_i. Enqueue into a full queue is allowed only in the same cycle as a dequeue. Without CSR_BYPASS_EN, req_ready_o is additionally gated by the hazard stall described under Optional Feature.
- Latency: an accepted request is visible at the head at the earliest one cycle later. Throughput is 1 per cycle when out_ready_i is held high.
- Head outputs: zero whenever out_valid_o=0, with no stale data.
- Ordering: strict FIFO. Circular read and write pointers, modulo DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged, both pointers advance.
- flush_i: count and pointers cleared next cycle. A same-cycle dequeue still completes at the write-back side, but the flush wins for the queue state.
- Reset (async assert): count=0, pointers=0, out_valid_o=0, all head outputs 0, req_ready_o=1 after reset.
- Reset mid-operation: all queued entries are discarded.

Optional Feature:
- Macro: CSR_BYPASS_EN.
- Defined: the youngest queued entry with csr_we=1 and csr_waddr == csr_addr_i forwards its wdata in place of csr_rdata_i. No stall is generated.
- Undefined: req_ready_o is forced 0 while any queued entry has csr_we=1 and csr_waddr == csr_addr_i (RAW hazard stall). csr_rdata_i is always used directly.

Decomposition:
- Package exu_csr_pkg holds:
  - typedef enum logic[1:0] csr_op_e {CSR_NOP, CSR_RW, CSR_RS, CSR_RC}.
  - A parametrised-by-localparam struct csr_entry_t {csr_we, csr_waddr, csr_wdata, reg_we, reg_waddr, reg_wdata}.
  - Localparam CSR_ZIMM_W=5.
- One sub-module: csr_out_fifo. A generic DEPTH-entry sync FIFO with flush, exposing entry array plus valid bits for the bypass CAM.

Test Plan:
- RW a=0x300, op1=0xDEADBEEF, rdata=0x1800, rd=5, out_ready=1 -> next cycle: csr_we=1, wdata=0xDEADBEEF, reg_we=1, reg_waddr=5, reg_wdata=0x1800.
- RSI zimm=0 on rdata=0x8 -> csr_we=0; RCI zimm=0x3 on rdata=0xF -> csr_we=1, wdata=0xC; rd=0 -> reg_we=0.
- DEPTH=2, out_ready=0, three back-to-back requests -> two enqueued, req_ready_o=0 and hold_o=1 on the third. Raise out_ready -> drains in order, third accepted in the same cycle as the first pop.
- int_assert_i=1 with valid RW -> no entry, out_valid_o stays 0. flush_i with 2 entries queued -> out_valid_o=0 next cycle.
- Queued RW 0x305 <= 0x100, then RS 0x305 src=0x1, csr_rdata_i=0x0:
  - bypass build: reg_wdata=0x100, wdata=0x101.
  - non-bypass build: stall until the first entry pops.
- Assert rst_n low with a full queue mid-cycle -> outputs 0 immediately (async), count=0 after release.
